// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector; next-state table is derived from PATTERN at elaboration (KMP rule).
// Define SEQDET_COUNT_EN to add the saturating match_cnt output.
module seq_detect_moore #(
  parameter int unsigned  N       = 5,
  parameter logic [N-1:0] PATTERN = N'(5'b11010),
  parameter int unsigned  OVERLAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x_in,
  input  logic       en,
  output logic       y_out
`ifdef SEQDET_COUNT_EN
  ,
  output logic [7:0] match_cnt
`endif
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_moore: N=%0d outside legal range 2..16", N);
  end

  localparam int unsigned SW = $clog2(N + 1);
  localparam int unsigned TW = (N + 1) * SW;

  typedef enum logic [SW-1:0] {
    S0 = SW'(0),
    SN = SW'(N)
  } state_t;

  function automatic logic pbit(input int unsigned i);
    return 1'(PATTERN >> i);
  endfunction

  // Longest j <= k+1 such that (matched prefix of length k, then b) ends with PATTERN's first j bits.
  function automatic logic [SW-1:0] step(input int unsigned k, input logic b);
    logic [31:0]  hist;
    logic         ok;
    int unsigned  best;
    hist = '0;
    best = 0;
    for (int unsigned i = 0; i < k; i++) hist = hist | (32'(pbit(N - 1 - i)) << i);
    hist = hist | (32'(b) << k);
    for (int unsigned j = 1; j <= k + 1; j++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < j; m++)
        if (1'(hist >> (k + 1 - j + m)) != pbit(N - 1 - m)) ok = 1'b0;
      if (ok) best = j;
    end
    return SW'(best);
  endfunction

  function automatic int unsigned border();
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned j = 1; j < N; j++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < j; m++)
        if (pbit(N - 1 - m) != pbit(j - 1 - m)) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  // Row SN restarts from the longest border (overlap) or from S0 (no overlap).
  function automatic logic [TW-1:0] build(input logic b);
    logic [TW-1:0] t;
    int unsigned   f;
    t = '0;
    f = (OVERLAP != 0) ? border() : 0;
    for (int unsigned k = 0; k < N; k++) t = t | (TW'(step(k, b)) << (k * SW));
    t = t | (TW'(step(f, b)) << (N * SW));
    return t;
  endfunction

  localparam logic [TW-1:0] NXT0 = build(1'b0);
  localparam logic [TW-1:0] NXT1 = build(1'b1);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q > SN)
      state_d = S0;
    else if (en)
      state_d = state_t'(SW'((x_in ? NXT1 : NXT0) >> (SW * int'(state_q))));
  end

  assign y_out = (state_q == SN);

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_cnt <= '0;
    else if (en && state_d == SN && match_cnt != 8'hFF)
      match_cnt <= match_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seq_detect_moore.sv
// Scoreboard bench for seq_detect_moore: four parameterisations share one stimulus stream.
`timescale 1ns/100ps
module tb_seq_detect_moore;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x_in = 1'b0;
  logic en = 1'b0;
  logic y_a, y_b, y_c, y_d;
  logic [3:0] y_all;
  assign y_all = {y_d, y_c, y_b, y_a};

`ifdef SEQDET_COUNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [31:0] cnt_all;
  assign cnt_all = {cnt_d, cnt_c, cnt_b, cnt_a};
`endif

  always #5 clk = ~clk;

  seq_detect_moore dut_a (
    .clk(clk), .rst(rst), .x_in(x_in), .en(en), .y_out(y_a)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_a)
`endif
  );
  seq_detect_moore #(.N(4), .PATTERN(4'b1011), .OVERLAP(1)) dut_b (
    .clk(clk), .rst(rst), .x_in(x_in), .en(en), .y_out(y_b)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_b)
`endif
  );
  seq_detect_moore #(.N(4), .PATTERN(4'b1011), .OVERLAP(0)) dut_c (
    .clk(clk), .rst(rst), .x_in(x_in), .en(en), .y_out(y_c)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_c)
`endif
  );
  seq_detect_moore #(.N(2), .PATTERN(2'b11), .OVERLAP(1)) dut_d (
    .clk(clk), .rst(rst), .x_in(x_in), .en(en), .y_out(y_d)
`ifdef SEQDET_COUNT_EN
    , .match_cnt(cnt_d)
`endif
  );

  typedef struct packed {
    logic [3:0]  chk;
    logic [3:0]  y;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  logic [31:0] ecnt = '0;
  int checks = 0;
  int errors = 0;

  // Expected response for the next rising edge; the count model advances on expected matches.
  task automatic drive(input logic x, input logic e, input logic [3:0] chk, input logic [3:0] y);
    exp_t it;
    @(negedge clk);
    x_in = x;
    en = e;
    for (int i = 0; i < 4; i++)
      if (e && y[i] && ecnt[i*8 +: 8] != 8'hFF) ecnt[i*8 +: 8] = ecnt[i*8 +: 8] + 8'd1;
    it.chk = chk;
    it.y = y;
    it.cnt = ecnt;
    sb.push_back(it);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (y_all !== 4'b0000) begin
      errors++;
      $display("FAIL %s y_out got %b exp 0000", tag, y_all);
    end
    checks++;
    if (dut_a.state_q !== dut_a.S0) begin
      errors++;
      $display("FAIL %s state got %0d exp 0", tag, dut_a.state_q);
    end
`ifdef SEQDET_COUNT_EN
    checks++;
    if (cnt_all !== 32'd0) begin
      errors++;
      $display("FAIL %s match_cnt got %h exp 0", tag, cnt_all);
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    ecnt = '0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
        if (e.chk[i]) begin
          checks++;
          if (y_all[i] !== e.y[i]) begin
            errors++;
            $display("FAIL y_out dut%0d got %b exp %b at %0t", i, y_all[i], e.y[i], $time);
          end
`ifdef SEQDET_COUNT_EN
          checks++;
          if (cnt_all[i*8 +: 8] !== e.cnt[i*8 +: 8]) begin
            errors++;
            $display("FAIL match_cnt dut%0d got %0d exp %0d at %0t", i, cnt_all[i*8 +: 8], e.cnt[i*8 +: 8], $time);
          end
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  int s1[11] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
  int e1[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int s2[7]  = '{1, 0, 1, 1, 0, 1, 1};
  int eb[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int ec[7]  = '{0, 0, 0, 1, 0, 0, 0};
  int s4x[12] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int s4e[12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
  int s4y[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};

  initial begin : stim
    int w;
    #1;
    check_reset_state("por");
    do_reset();

    // Default pattern 11010, overlapping stream.
    for (int i = 0; i < 11; i++) drive(1'(s1[i]), 1'b1, 4'b0001, 4'(e1[i]));

    // 1011 with and without overlap on the same stream.
    do_reset();
    for (int i = 0; i < 7; i++)
      drive(1'(s2[i]), 1'b1, 4'b0110, 4'((ec[i] << 2) | (eb[i] << 1)));

    // Mid-sequence reset discards the 1101 prefix.
    do_reset();
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    @(posedge clk);
    #1.5;
    rst = 1'b0;
    ecnt = '0;
    #1;
    check_reset_state("mid_reset");
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 1'b1, 4'b0001, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001, 4'b0001);

    // Pattern interleaved with disabled edges carrying random data.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (s4e[i] != 0) drive(1'(s4x[i]), 1'b1, 4'b0001, 4'(s4y[i]));
      else             drive(1'($urandom_range(0, 1)), 1'b0, 4'b0001, 4'(s4y[i]));
    end

    // Pattern 11 with a long run of ones: flag stays high, counter saturates.
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 4'b1000, (i == 0) ? 4'b0000 : 4'b1000);

    @(negedge clk);
    en = 1'b0;
    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 The block SHALL have parameter N, default 5, meaning pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 5'b11010, meaning the N-bit target sequence; PATTERN[N-1] is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches detected, 0 = detector restarts after each match.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port x_in, input, 1 bit, the serial data bit.
REQ-007 The block SHALL have port en, input, 1 bit, the sample enable; x_in is consumed only on edges where en=1.
REQ-008 The block SHALL have port y_out, output, 1 bit, the Moore match flag.
REQ-009 The block SHALL have port match_cnt, output, 8 bits, the saturating match count; this port exists only when SEQDET_COUNT_EN is defined.

Function
REQ-010 The block SHALL implement a Moore FSM with states S0..SN, where Sk means the last k sampled bits equal PATTERN[N-1 : N-k].
REQ-011 On an edge with en=1 from state Sk (k<N), the next state SHALL be Sj, where j is the largest value <=k+1 such that the last j bits (the matched prefix plus x_in) equal PATTERN[N-1 : N-j]; this is the KMP failure-function rule, with the transition table computed at elaboration from PATTERN.
REQ-012 On an edge with en=1 from SN, when OVERLAP=1, the next state SHALL be computed as in REQ-011 from Sf, where f is the longest proper prefix of PATTERN that is also its suffix.
REQ-013 On an edge with en=1 from SN, when OVERLAP=0, the next state SHALL be computed as in REQ-011 from S0.
REQ-014 On an edge with en=0, the state SHALL hold and no bit SHALL be consumed.
REQ-015 y_out SHALL be decoded from the state register only (1 iff state==SN), with no combinational path from x_in or en.
REQ-016 Latency: y_out SHALL rise on the same clk edge that samples the final matching bit and remain high until the next edge with en=1 that leaves SN.
REQ-017 y_out SHALL stay high across consecutive enabled edges when each bit completes a new match, for example PATTERN=1111 with OVERLAP=1 and a run of 1s.
REQ-018 The state register SHALL be ceil(log2(N+1)) bits wide, and unreachable encodings SHALL transition to S0.
REQ-019 Elaboration SHALL fail, via a generate-time error, if N is outside 2..16.

Reset
REQ-020 rst=0 SHALL force state S0, y_out=0 and match_cnt=0 immediately, without waiting for a clock edge.
REQ-021 A reset asserted mid-sequence SHALL discard partial matches, so a match requires N fresh bits after release.
REQ-022 The first edge after rst rises SHALL operate normally; no warm-up cycle is inserted.

Configuration
REQ-023 With macro SEQDET_COUNT_EN defined, match_cnt SHALL increment by 1 on every enabled edge whose next state is SN, and SHALL saturate at 255.
REQ-024 Without SEQDET_COUNT_EN, the match_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-025 Defaults, clk period 10 ns, en=1, stream 0,1,1,0,1,0,1,1,0,1,0 -> y_out high for exactly one cycle after the 6th bit and after the 11th bit; no other highs.
REQ-026 N=4, PATTERN=4'b1011, OVERLAP=1, stream 1,0,1,1,0,1,1 -> y_out high after bit 4 and after bit 7; match_cnt=2 (with SEQDET_COUNT_EN).
REQ-027 Same stream as REQ-026 with OVERLAP=0 -> y_out high after bit 4 only; match_cnt=1.
REQ-028 Defaults, bits 1,1,0,1 sampled, then rst pulsed low for 3 ns between edges, then bit 0 -> y_out stays 0, state=S0 observed during reset, no match.
REQ-029 Defaults, pattern bits sent with en=0 on alternate edges and x_in toggling randomly on those edges -> match detected exactly as for the en=1 stream; y_out holds while en=0.
REQ-030 SEQDET_COUNT_EN defined, N=2, PATTERN=2'b11, OVERLAP=1, 300 consecutive 1s -> y_out stays high from bit 2 onward; match_cnt reaches 255 and holds.
